// File: rtl/tron_pkg.sv
// Shared types and constants for the Tron round/match judge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tron_pkg;

  // Width of one BCD score digit
  localparam int SCORE_W = 4;

  // Round/match controller states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    RESOLVE    = 3'd2,
    REPORT     = 3'd3,
    HOLD       = 3'd4,
    MATCH_OVER = 3'd5
  } judge_state_t;

  // Winner codes; also reused as the latched round result (DRAW = tie)
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Single-digit BCD increment that sticks at the match-ending score.
  // Values stay within 0..9, so the binary increment is already valid BCD.
  function automatic logic [SCORE_W-1:0] bcd_sat_inc(input logic [SCORE_W-1:0] v,
                                                     input logic [SCORE_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/round_judge_tick_timer.sv
// Tick-gated up-counter with synchronous clear and terminal-count flag.
// Latency: done is combinational on the tick that reaches LIMIT.
// Backpressure: none; counts only while en is high, saturates at LIMIT.
module tick_timer #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic clear_b,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic done
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Count enabled ticks from zero; clear wins over counting, hold at LIMIT
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && tick && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

  // Flag the tick that brings the count to LIMIT; a zero limit expires at once
  assign done = (LIMIT == 0) ? en : (en && tick && (count == LAST));

endmodule

// File: rtl/round_judge.sv
// Tron round/match judge: decides round winners (with tie window), pulses score events, keeps tallies.
// Latency: result pulse one cycle after the deciding crash/tick; PLAY one cycle after start.
// Backpressure: none; freezes play (round_active=0) between rounds. Optional TIE_BOTH_EN: ties score both.
module round_judge
  import tron_pkg::*;
#(
  parameter int WIN_SCORE     = 9,
  parameter int RESOLVE_TICKS = 2,
  parameter int HOLD_TICKS    = 60
) (
  input  logic               clk,
  input  logic               clear_b,
  input  logic               start,
  input  logic               tick,
  input  logic               crash1,
  input  logic               crash2,
  output logic               round_active,
  output logic               score_en,
  output logic               p1_win,
  output logic               p2_win,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  judge_state_t state, next_state;

  // Round result: survivor while resolving, final winner or DRAW in REPORT
  logic [1:0] res_q, res_d;

  logic resolve_done, hold_done;
  logic p1_pt, p2_pt;
  logic match_won;

  // Tie window after the first crash
  tick_timer #(.LIMIT(RESOLVE_TICKS)) u_resolve_timer (
    .clk     (clk),
    .clear_b (clear_b),
    .clr     (state == PLAY),
    .en      (state == RESOLVE),
    .tick    (tick),
    .done    (resolve_done)
  );

  // Freeze period after the result is reported
  tick_timer #(.LIMIT(HOLD_TICKS)) u_hold_timer (
    .clk     (clk),
    .clear_b (clear_b),
    .clr     (state == REPORT),
    .en      (state == HOLD),
    .tick    (tick),
    .done    (hold_done)
  );

  assign match_won = (p1_score == WIN_VAL) || (p2_score == WIN_VAL);

  // State register
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and round-result decision
  always_comb begin
    next_state = state;
    res_d      = res_q;
    case (state)
      IDLE: begin
        if (start) next_state = PLAY;
      end
      PLAY: begin
        if (crash1 && crash2) begin
          res_d      = WIN_DRAW;
          next_state = REPORT;
        end else if (crash1 || crash2) begin
          // Remember the survivor; it wins unless the other crashes in the window
          res_d      = crash1 ? WIN_P2 : WIN_P1;
          next_state = (RESOLVE_TICKS == 0) ? REPORT : RESOLVE;
        end
      end
      RESOLVE: begin
        // A survivor crash beats a coincident expiring tick: it is a tie
        if (((res_q == WIN_P1) && crash1) || ((res_q == WIN_P2) && crash2)) begin
          res_d      = WIN_DRAW;
          next_state = REPORT;
        end else if (resolve_done) begin
          next_state = REPORT;
        end
      end
      REPORT: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (hold_done) next_state = match_won ? MATCH_OVER : PLAY;
      end
      MATCH_OVER: begin
        if (start) next_state = PLAY;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Which players earn a point from the latched result
  always_comb begin
`ifdef TIE_BOTH_EN
    p1_pt = (res_q == WIN_P1) || (res_q == WIN_DRAW);
    p2_pt = (res_q == WIN_P2) || (res_q == WIN_DRAW);
`else
    p1_pt = (res_q == WIN_P1);
    p2_pt = (res_q == WIN_P2);
`endif
  end

  // Result latch and tallies: bump once as REPORT ends, clear on a new match
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      res_q    <= WIN_NONE;
      p1_score <= '0;
      p2_score <= '0;
    end else begin
      res_q <= res_d;
      if ((state == MATCH_OVER) && start) begin
        p1_score <= '0;
        p2_score <= '0;
      end else if (state == REPORT) begin
        if (p1_pt) p1_score <= bcd_sat_inc(p1_score, WIN_VAL);
        if (p2_pt) p2_score <= bcd_sat_inc(p2_score, WIN_VAL);
      end
    end
  end

  // Moore outputs decoded from the state and latched result
  always_comb begin
    round_active = (state == PLAY) || (state == RESOLVE);
    score_en     = (state == REPORT);
    p1_win       = (state == REPORT) && p1_pt;
    p2_win       = (state == REPORT) && p2_pt;
    match_over   = (state == MATCH_OVER);
    winner       = WIN_NONE;
    if (state == MATCH_OVER) begin
      if ((p1_score == WIN_VAL) && (p2_score == WIN_VAL)) winner = WIN_DRAW;
      else if (p1_score == WIN_VAL)                      winner = WIN_P1;
      else                                               winner = WIN_P2;
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge: round-level reference model with random timing.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench). Honours TIE_BOTH_EN when defined for the build.
module tb_round_judge;

  localparam int WIN_SCORE     = 9;
  localparam int RESOLVE_TICKS = 2;
  localparam int HOLD_TICKS    = 60;
`ifdef TIE_BOTH_EN
  localparam bit TIE_BOTH = 1'b1;
`else
  localparam bit TIE_BOTH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear_b = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       crash1 = 1'b0;
  logic       crash2 = 1'b0;
  logic       round_active, score_en, p1_win, p2_win, match_over;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;

  int checks = 0;
  int failures = 0;
  int n_en, n_p1, n_p2;   // pulses seen since last cleared
  int m1, m2;             // reference tallies

  always #5 clk = ~clk;

  round_judge #(
    .WIN_SCORE     (WIN_SCORE),
    .RESOLVE_TICKS (RESOLVE_TICKS),
    .HOLD_TICKS    (HOLD_TICKS)
  ) dut (
    .clk          (clk),
    .clear_b      (clear_b),
    .start        (start),
    .tick         (tick),
    .crash1       (crash1),
    .crash2       (crash2),
    .round_active (round_active),
    .score_en     (score_en),
    .p1_win       (p1_win),
    .p2_win       (p2_win),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .match_over   (match_over),
    .winner       (winner)
  );

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs, cross the edge, sample 1ns later and tally pulses
  task automatic cycle(input bit t, input bit c1, input bit c2, input bit s);
    tick = t; crash1 = c1; crash2 = c2; start = s;
    @(posedge clk);
    #1;
    if (score_en === 1'b1) n_en++;
    if (p1_win === 1'b1) n_p1++;
    if (p2_win === 1'b1) n_p2++;
    if (p1_win === 1'b1 || p2_win === 1'b1) begin
      checks++;
      if (score_en !== 1'b1) begin
        failures++;
        $display("FAIL win_pulse_alone score_en=%b required 1", score_en);
      end
    end
  endtask

  // Press start from IDLE or MATCH_OVER; expect a fresh match in PLAY
  task automatic start_match(input string tag);
    cycle(rb(), rb(), rb(), 1'b1);
    m1 = 0; m2 = 0;
    checks++;
    if (round_active !== 1'b1 || match_over !== 1'b0 || winner !== 2'b00 ||
        p1_score !== 4'd0 || p2_score !== 4'd0 || score_en !== 1'b0) begin
      failures++;
      $display("FAIL %s_start ra=%b mo=%b win=%b s=%0d/%0d en=%b required ra=1 mo=0 win=00 s=0/0 en=0",
               tag, round_active, match_over, winner, p1_score, p2_score, score_en);
    end
  endtask

  // One round from PLAY. kind 0: simultaneous crash; 1/2: that player crashes
  // first and the other crashes d ticks later (never, if d >= RESOLVE_TICKS).
  task automatic play_round(input int kind, input int d, input string tag);
    int  rwin, ticks_seen, hold_ticks, guard;
    bit  t, p1e, p2e, over_e;
    logic [1:0] win_e;
    rwin = (kind == 0 || d < RESOLVE_TICKS) ? 0 : ((kind == 1) ? 2 : 1);
    p1e  = (rwin == 1) || (rwin == 0 && TIE_BOTH);
    p2e  = (rwin == 2) || (rwin == 0 && TIE_BOTH);
    n_en = 0; n_p1 = 0; n_p2 = 0;

    repeat ($urandom_range(0, 3)) cycle(rb(), 1'b0, 1'b0, rb());
    checks++;
    if (round_active !== 1'b1) begin
      failures++;
      $display("FAIL %s_active round_active=%b required 1", tag, round_active);
    end

    if (kind == 0) begin
      cycle(rb(), 1'b1, 1'b1, rb());
    end else begin
      cycle(1'b0, kind == 1, kind == 2, rb());
      ticks_seen = 0;
      if (d < RESOLVE_TICKS) begin
        while (ticks_seen < d) begin
          t = rb();
          cycle(t, (kind == 1) ? rb() : 1'b0, (kind == 2) ? rb() : 1'b0, rb());
          ticks_seen += int'(t);
        end
        cycle(rb(), (kind == 2) ? 1'b1 : rb(), (kind == 1) ? 1'b1 : rb(), rb());
      end else begin
        while (ticks_seen < RESOLVE_TICKS) begin
          t = rb();
          cycle(t, (kind == 1) ? rb() : 1'b0, (kind == 2) ? rb() : 1'b0, rb());
          ticks_seen += int'(t);
        end
      end
    end

    // The report cycle must follow the deciding edge directly
    checks++;
    if (score_en !== 1'b1 || p1_win !== p1e || p2_win !== p2e || round_active !== 1'b0) begin
      failures++;
      $display("FAIL %s_report en=%b p1=%b p2=%b ra=%b required en=1 p1=%b p2=%b ra=0",
               tag, score_en, p1_win, p2_win, round_active, p1e, p2e);
    end
    if (p1e && m1 < WIN_SCORE) m1++;
    if (p2e && m2 < WIN_SCORE) m2++;

    cycle(1'b0, rb(), rb(), rb());
    hold_ticks = 0; guard = 0;
    while (round_active === 1'b0 && match_over === 1'b0 && guard < 2000) begin
      t = rb();
      cycle(t, rb(), rb(), rb());
      hold_ticks += int'(t);
      guard++;
    end

    over_e = (m1 == WIN_SCORE) || (m2 == WIN_SCORE);
    win_e  = !over_e ? 2'b00 : (m1 == WIN_SCORE && m2 == WIN_SCORE) ? 2'b11 :
             (m1 == WIN_SCORE) ? 2'b01 : 2'b10;
    checks++;
    if (guard >= 2000 || hold_ticks != HOLD_TICKS) begin
      failures++;
      $display("FAIL %s_hold frozen_ticks=%0d required %0d", tag, hold_ticks, HOLD_TICKS);
    end
    checks++;
    if (n_en != 1 || n_p1 != int'(p1e) || n_p2 != int'(p2e)) begin
      failures++;
      $display("FAIL %s_pulses en=%0d p1=%0d p2=%0d required 1 %0d %0d", tag, n_en, n_p1, n_p2, p1e, p2e);
    end
    checks++;
    if (p1_score !== 4'(m1) || p2_score !== 4'(m2) || match_over !== over_e ||
        winner !== win_e || round_active !== !over_e) begin
      failures++;
      $display("FAIL %s_after s=%0d/%0d mo=%b win=%b ra=%b required s=%0d/%0d mo=%b win=%b ra=%b",
               tag, p1_score, p2_score, match_over, winner, round_active, m1, m2, over_e, win_e, !over_e);
    end
  endtask

  task automatic test_reset();
    clear_b = 1'b0;
    repeat (2) cycle(rb(), rb(), rb(), 1'b1);
    checks++;
    if (round_active !== 1'b0 || score_en !== 1'b0 || p1_win !== 1'b0 || p2_win !== 1'b0 ||
        p1_score !== 4'd0 || p2_score !== 4'd0 || match_over !== 1'b0 || winner !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs ra=%b en=%b w=%b%b s=%0d/%0d mo=%b win=%b required all 0",
               round_active, score_en, p1_win, p2_win, p1_score, p2_score, match_over, winner);
    end
    clear_b = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (round_active !== 1'b0 || score_en !== 1'b0 || match_over !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_crash ra=%b en=%b mo=%b required 0 0 0", round_active, score_en, match_over);
    end
  endtask

  task automatic test_basic_rounds();
    start_match("basic");
    play_round(1, RESOLVE_TICKS, "p2_survives");
    play_round(0, 0, "same_cycle_tie");
    play_round(2, 1, "late_crash_tie");
    play_round(1, 0, "next_cycle_tie");
  endtask

  task automatic test_clear_in_resolve();
    n_en = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (round_active !== 1'b1 || score_en !== 1'b0) begin
      failures++;
      $display("FAIL resolve_entry ra=%b en=%b required 1 0", round_active, score_en);
    end
    clear_b = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    clear_b = 1'b1;
    checks++;
    if (round_active !== 1'b0 || score_en !== 1'b0 || p1_win !== 1'b0 || p2_win !== 1'b0 ||
        p1_score !== 4'd0 || p2_score !== 4'd0 || match_over !== 1'b0 || winner !== 2'b00) begin
      failures++;
      $display("FAIL clear_in_resolve ra=%b en=%b s=%0d/%0d mo=%b win=%b required all 0",
               round_active, score_en, p1_score, p2_score, match_over, winner);
    end
    repeat (5) cycle(rb(), rb(), rb(), 1'b0);
    checks++;
    if (n_en != 0 || round_active !== 1'b0) begin
      failures++;
      $display("FAIL clear_stays_idle pulses=%0d ra=%b required 0 0", n_en, round_active);
    end
  endtask

  task automatic test_match_p1();
    start_match("match_p1");
    for (int i = 0; i < WIN_SCORE; i++) play_round(2, RESOLVE_TICKS + $urandom_range(0, 2), "p1_streak");
    n_en = 0;
    repeat (20) cycle(rb(), rb(), rb(), 1'b0);
    checks++;
    if (n_en != 0 || match_over !== 1'b1 || winner !== 2'b01 || p1_score !== 4'd9 || p2_score !== 4'd0) begin
      failures++;
      $display("FAIL match_over_hold pulses=%0d mo=%b win=%b s=%0d/%0d required 0 1 01 9/0",
               n_en, match_over, winner, p1_score, p2_score);
    end
    start_match("rematch");
  endtask

  task automatic test_tie_boundary();
    for (int i = 0; i < WIN_SCORE - 1; i++) begin
      play_round(2, RESOLVE_TICKS, "climb_p1");
      play_round(1, RESOLVE_TICKS, "climb_p2");
    end
    play_round(0, 0, "tie_at_8");
    if (match_over !== 1'b1) play_round(1, RESOLVE_TICKS, "p2_finish");
    checks++;
    if (winner !== (TIE_BOTH ? 2'b11 : 2'b10)) begin
      failures++;
      $display("FAIL tie_boundary_winner winner=%b required %b", winner, TIE_BOTH ? 2'b11 : 2'b10);
    end
  endtask

  task automatic test_random_rounds();
    start_match("random");
    for (int i = 0; i < 30; i++) begin
      if (match_over === 1'b1) break;
      play_round($urandom_range(0, 2), $urandom_range(0, RESOLVE_TICKS + 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_rounds();
    test_clear_in_resolve();
    test_match_p1();
    test_tie_boundary();
    test_random_rounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
